// File: rtl/tinyflash_seq.sv
// tinyflash flash-ADC conversion sequencer: track/hold/latch timing, bubble
// correction, thermometer-to-binary conversion and batch averaging.

module tinyflash_maj3 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);
  assign y = (a & b) | (a & c) | (b & c);
endmodule

module tinyflash_seq #(
  parameter int TRACK_CYC  = 4,
  parameter int SETTLE_CYC = 2,
  parameter int AVG_LOG2   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        cont,
  input  logic [14:0] therm,
  input  logic        out_ready,
  output logic        sh_track,
  output logic        cmp_latch,
  output logic        busy,
  output logic        out_valid,
  output logic [3:0]  out_code,
  output logic        out_err
);

  localparam int AW   = 4 + AVG_LOG2;
  localparam int SW   = AVG_LOG2 + 1;
  localparam int CMAX = (TRACK_CYC > SETTLE_CYC) ? TRACK_CYC : SETTLE_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [SW-1:0] LAST_SMP = SW'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {S_IDLE, S_TRACK, S_HOLD, S_LATCH, S_CAPTURE, S_OUT} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   smp_q, smp_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic            err_q, err_d;
  logic [3:0]      code_q, code_d;
  logic            oerr_q, oerr_d;

  // Ends padded with the implied references: below range is 1, above is 0.
  logic [16:0] t_ext;
  logic [14:0] cor;
  logic [3:0]  pop;
  logic        bubble;
  logic [AW-1:0] acc_sum;
  logic        batch_go;

  assign t_ext = {1'b0, therm, 1'b1};

  tinyflash_maj3 u_maj[14:0] (
    .a (t_ext[14:0]),
    .b (t_ext[15:1]),
    .c (t_ext[16:2]),
    .y (cor)
  );

  always_comb begin
    pop = '0;
    for (int i = 0; i < 15; i++) pop = pop + 4'(cor[i]);
  end

  assign bubble  = |(therm[14:1] & ~therm[13:0]);
  assign acc_sum = acc_q + AW'(pop);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    smp_d    = smp_q;
    acc_d    = acc_q;
    err_d    = err_q;
    code_d   = code_q;
    oerr_d   = oerr_q;
    batch_go = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start || cont) begin
          state_d  = S_TRACK;
          batch_go = 1'b1;
        end
      end
      S_TRACK: begin
        if (cnt_q == CW'(TRACK_CYC - 1)) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == CW'(SETTLE_CYC - 1)) begin
          state_d = S_LATCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LATCH: state_d = S_CAPTURE;
      S_CAPTURE: begin
        // Result registers load from the same sum the accumulator takes.
        acc_d = acc_sum;
        err_d = err_q | bubble;
        smp_d = smp_q + SW'(1);
        if (smp_q == LAST_SMP) begin
          state_d = S_OUT;
          code_d  = acc_sum[AW-1:AVG_LOG2];
          oerr_d  = err_q | bubble;
        end else begin
          state_d = S_TRACK;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (start || cont) begin
            state_d  = S_TRACK;
            batch_go = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (batch_go) begin
      cnt_d = '0;
      smp_d = '0;
      acc_d = '0;
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      smp_q   <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= '0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      smp_q   <= smp_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      code_q  <= code_d;
      oerr_q  <= oerr_d;
    end
  end

  assign sh_track  = (state_q == S_TRACK);
  assign cmp_latch = (state_q == S_LATCH);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign out_code  = code_q;
  assign out_err   = oerr_q;

endmodule

// File: tb/tb_tinyflash_seq.sv
// Randomized self-checking bench for tinyflash_seq against a behavioural
// model of the conversion rules (defaults: N=4, P=8).

module tb_tinyflash_seq;
  logic        clk, rst_n, start, cont, out_ready;
  logic [14:0] therm;
  logic        sh_track, cmp_latch, busy, out_valid, out_err;
  logic [3:0]  out_code;

  int n_chk = 0;
  int n_pass = 0;
  logic [14:0] stim [4];

  tinyflash_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .therm(therm),
    .out_ready(out_ready), .sh_track(sh_track), .cmp_latch(cmp_latch),
    .busy(busy), .out_valid(out_valid), .out_code(out_code), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Per-sample code: majority-filter with implied end references, then count ones.
  function automatic int m_code(input logic [14:0] t);
    int b[17];
    int n;
    n = 0;
    b[0] = 1;
    b[16] = 0;
    for (int i = 0; i < 15; i++) b[i+1] = int'(t[i]);
    for (int i = 1; i <= 15; i++) if (b[i-1] + b[i] + b[i+1] >= 2) n++;
    return n;
  endfunction

  function automatic bit m_bub(input logic [14:0] t);
    for (int i = 0; i < 14; i++) if (t[i+1] && !t[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_avg();
    int s;
    s = 0;
    for (int k = 0; k < 4; k++) s += m_code(stim[k]);
    return s / 4;
  endfunction

  function automatic bit m_err();
    bit e;
    e = 1'b0;
    for (int k = 0; k < 4; k++) e |= m_bub(stim[k]);
    return e;
  endfunction

  function automatic logic [14:0] rnd_therm();
    logic [14:0] v;
    int lvl;
    lvl = $urandom_range(0, 15);
    v = 15'((32'd1 << lvl) - 32'd1);
    if ($urandom_range(0, 2) == 0) v = 15'($urandom);
    return v;
  endfunction

  // Called at the negedge right after the batch start edge; returns at the
  // negedge where out_valid is first seen (or after a cycle budget).
  task automatic run_batch(input int pulse_at, output int lat, output int nlat,
                           output bit shape_bad, output bit busy_bad);
    int cyc;
    bit [2:0] h;
    cyc = 0; h = '0; nlat = 0; shape_bad = 0; busy_bad = 0;
    while (!out_valid && cyc < 200) begin
      start = (cyc == pulse_at);
      if (!busy) busy_bad = 1;
      if (cmp_latch) begin
        if (h !== 3'b100) shape_bad = 1;
        therm = stim[nlat % 4];
        nlat++;
      end
      h = {h[1:0], sh_track};
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    lat = cyc;
  endtask

  task automatic test_reset;
    #3;
    n_chk++; if ({sh_track, cmp_latch, busy, out_valid, out_err, out_code} !== 9'd0)
      $display("FAIL reset_outputs got %b want 0", {sh_track, cmp_latch, busy, out_valid, out_err, out_code}); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_idle busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_single;
    int lat, nl; bit sb, bb;
    for (int k = 0; k < 4; k++) stim[k] = 15'h007F;
    cont = 0;
    start = 1; @(negedge clk); start = 0;
    run_batch(-1, lat, nl, sb, bb);
    n_chk++; if (lat !== 32) $display("FAIL single_latency got %0d want 32", lat); else n_pass++;
    n_chk++; if (nl !== 4) $display("FAIL single_latch_count got %0d want 4", nl); else n_pass++;
    n_chk++; if (sb !== 1'b0) $display("FAIL single_latch_shape got %b want 0", sb); else n_pass++;
    n_chk++; if (bb !== 1'b0) $display("FAIL single_busy_drop got %b want 0", bb); else n_pass++;
    n_chk++; if (out_code !== 4'(m_avg())) $display("FAIL single_code got %0d want %0d", out_code, m_avg()); else n_pass++;
    n_chk++; if (out_err !== 1'b0) $display("FAIL single_err got %b want 0", out_err); else n_pass++;
    out_ready = 1; @(negedge clk); out_ready = 0;
    n_chk++; if ({out_valid, busy} !== 2'b00) $display("FAIL single_after_hs got %b want 00", {out_valid, busy}); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int bad;
    start = 1; @(negedge clk); start = 0;
    repeat (4) @(negedge clk);
    n_chk++; if ({sh_track, busy} !== 2'b01) $display("FAIL midhold_pre got %b want 01", {sh_track, busy}); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({sh_track, cmp_latch, busy, out_valid, out_err, out_code} !== 9'd0)
      $display("FAIL midhold_reset got %b want 0", {sh_track, cmp_latch, busy, out_valid, out_err, out_code}); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if ({sh_track, cmp_latch, busy, out_valid} !== 4'd0) bad++;
    end
    n_chk++; if (bad !== 0) $display("FAIL post_reset_quiet got %0d bad cycles want 0", bad); else n_pass++;
  endtask

  task automatic test_bubble;
    int lat, nl; bit sb, bb;
    for (int k = 0; k < 4; k++) stim[k] = 15'b000000001011111;
    n_chk++; if (m_code(stim[0]) !== 6) $display("FAIL model_bubble_code got %0d want 6", m_code(stim[0])); else n_pass++;
    start = 1; @(negedge clk); start = 0;
    run_batch(-1, lat, nl, sb, bb);
    n_chk++; if (out_code !== 4'd6) $display("FAIL bubble_code got %0d want 6", out_code); else n_pass++;
    n_chk++; if (out_err !== 1'b1) $display("FAIL bubble_err got %b want 1", out_err); else n_pass++;
    out_ready = 1; @(negedge clk); out_ready = 0;
    for (int k = 0; k < 4; k++) stim[k] = 15'h003F;
    start = 1; @(negedge clk); start = 0;
    run_batch(-1, lat, nl, sb, bb);
    n_chk++; if (out_code !== 4'd6) $display("FAIL clean_code got %0d want 6", out_code); else n_pass++;
    n_chk++; if (out_err !== 1'b0) $display("FAIL clean_err got %b want 0", out_err); else n_pass++;
    out_ready = 1; @(negedge clk); out_ready = 0;
  endtask

  task automatic test_avg_trunc;
    int lat, nl; bit sb, bb;
    stim[0] = 15'h0007; stim[1] = 15'h000F; stim[2] = 15'h000F; stim[3] = 15'h000F;
    start = 1; @(negedge clk); start = 0;
    run_batch(-1, lat, nl, sb, bb);
    n_chk++; if (out_code !== 4'd3) $display("FAIL trunc_code got %0d want 3", out_code); else n_pass++;
    out_ready = 1; @(negedge clk); out_ready = 0;
    for (int k = 0; k < 4; k++) stim[k] = 15'h7FFF;
    start = 1; @(negedge clk); start = 0;
    run_batch(-1, lat, nl, sb, bb);
    n_chk++; if (out_code !== 4'd15) $display("FAIL full_scale_code got %0d want 15", out_code); else n_pass++;
    n_chk++; if (out_err !== 1'b0) $display("FAIL full_scale_err got %b want 0", out_err); else n_pass++;
    out_ready = 1; @(negedge clk); out_ready = 0;
  endtask

  task automatic test_backpressure;
    int lat, nl, ec; bit sb, bb, ee;
    for (int k = 0; k < 4; k++) stim[k] = rnd_therm();
    ec = m_avg(); ee = m_err();
    cont = 1;
    start = 1; @(negedge clk); start = 0;
    run_batch(-1, lat, nl, sb, bb);
    n_chk++; if (lat !== 32) $display("FAIL bp_latency got %0d want 32", lat); else n_pass++;
    repeat (10) begin
      @(negedge clk);
      n_chk++; if (out_valid !== 1'b1) $display("FAIL bp_valid got %b want 1", out_valid); else n_pass++;
      n_chk++; if ({out_code, out_err} !== {4'(ec), ee}) $display("FAIL bp_result got %0d/%b want %0d/%b", out_code, out_err, ec, ee); else n_pass++;
      n_chk++; if ({cmp_latch, sh_track} !== 2'b00) $display("FAIL bp_quiet got %b want 00", {cmp_latch, sh_track}); else n_pass++;
    end
    out_ready = 1; @(negedge clk); out_ready = 0;
    n_chk++; if ({out_valid, sh_track} !== 2'b01) $display("FAIL cont_restart got %b want 01", {out_valid, sh_track}); else n_pass++;
    cont = 0;
    for (int k = 0; k < 4; k++) stim[k] = rnd_therm();
    run_batch(-1, lat, nl, sb, bb);
    n_chk++; if (lat !== 32) $display("FAIL cont_off_latency got %0d want 32", lat); else n_pass++;
    n_chk++; if ({out_code, out_err} !== {4'(m_avg()), m_err()}) $display("FAIL cont_off_result got %0d/%b want %0d/%b", out_code, out_err, m_avg(), m_err()); else n_pass++;
    out_ready = 1; @(negedge clk); out_ready = 0;
    n_chk++; if (busy !== 1'b0) $display("FAIL cont_off_idle busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_start_ignored;
    int lat, nl, extra; bit sb, bb;
    for (int k = 0; k < 4; k++) stim[k] = rnd_therm();
    start = 1; @(negedge clk); start = 0;
    run_batch(2, lat, nl, sb, bb);
    n_chk++; if (lat !== 32) $display("FAIL ign_latency got %0d want 32", lat); else n_pass++;
    n_chk++; if (nl !== 4) $display("FAIL ign_latch_count got %0d want 4", nl); else n_pass++;
    out_ready = 1; @(negedge clk); out_ready = 0;
    extra = 0;
    repeat (20) begin
      if (busy || cmp_latch) extra++;
      @(negedge clk);
    end
    n_chk++; if (extra !== 0) $display("FAIL ign_extra_batch got %0d want 0", extra); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int lat, nl; bit sb, bb;
    for (int k = 0; k < 4; k++) stim[k] = rnd_therm();
    start = 1; @(negedge clk); start = 0;
    run_batch(-1, lat, nl, sb, bb);
    start = 1; out_ready = 1; @(negedge clk); start = 0; out_ready = 0;
    n_chk++; if ({out_valid, sh_track} !== 2'b01) $display("FAIL b2b_restart got %b want 01", {out_valid, sh_track}); else n_pass++;
    for (int k = 0; k < 4; k++) stim[k] = rnd_therm();
    run_batch(-1, lat, nl, sb, bb);
    n_chk++; if (lat !== 32) $display("FAIL b2b_latency got %0d want 32", lat); else n_pass++;
    n_chk++; if ({out_code, out_err} !== {4'(m_avg()), m_err()}) $display("FAIL b2b_result got %0d/%b want %0d/%b", out_code, out_err, m_avg(), m_err()); else n_pass++;
    out_ready = 1; @(negedge clk); out_ready = 0;
  endtask

  task automatic test_random;
    int lat, nl; bit sb, bb;
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < 4; k++) stim[k] = rnd_therm();
      out_ready = it[0];
      start = 1; @(negedge clk); start = 0;
      run_batch(-1, lat, nl, sb, bb);
      n_chk++; if (lat !== 32) $display("FAIL rnd%0d_latency got %0d want 32", it, lat); else n_pass++;
      n_chk++; if ({out_code, out_err} !== {4'(m_avg()), m_err()}) $display("FAIL rnd%0d_result got %0d/%b want %0d/%b", it, out_code, out_err, m_avg(), m_err()); else n_pass++;
      out_ready = 1; @(negedge clk); out_ready = 0;
      n_chk++; if ({out_valid, busy} !== 2'b00) $display("FAIL rnd%0d_after_hs got %b want 00", it, {out_valid, busy}); else n_pass++;
    end
  endtask

  initial begin
    rst_n = 0; start = 0; cont = 0; out_ready = 0; therm = '0;
    test_reset();
    test_single();
    test_reset_mid();
    test_bubble();
    test_avg_trunc();
    test_backpressure();
    test_start_ignored();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
